mpeg_stream_ctl: RTL
====================

// Module: mpeg_stream_ctl
// PURPOSE
//  Sequences the mpeg2video decoder: queues host register writes and drives them onto the
//  decoder's reg_addr/reg_dta_in/reg_wr_en with a fixed post-write gap. Gates the laserdisc
//  byte stream into stream_data/stream_valid; config writes take priority, bytes pass only
//  while play is set and the decoder is not busy. Sits between the LDP command logic and mpeg.
// PARAMETERS
//  CFG_DEPTH     4       config FIFO entries (power of 2, >=2)
//  REG_GAP       3       idle cycles after each reg write before next write/stream byte (>=1)
//  BUSY_TIMEOUT  65535   busy cycles in S_RUN before stall flag sets (16-bit)
// PORTS
//  sys_clk       in   1   single clock, all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  cfg_wr        in   1   push {cfg_addr,cfg_data} into config FIFO
//  cfg_addr      in   5   decoder register address
//  cfg_data      in   32  decoder register data
//  cfg_full      out  1   config FIFO full (combinational from count)
//  play          in   1   level: permit streaming
//  flush         in   1   pulse: abort, empty FIFO, clear counters/flags
//  src_data      in   8   upstream stream byte
//  src_valid     in   1   upstream byte valid
//  src_ready     out  1   byte accepted when src_valid&src_ready
//  busy          in   1   decoder busy (back-pressure)
//  reg_addr      out  5   to decoder
//  reg_dta_in    out  32  to decoder
//  reg_wr_en     out  1   one-cycle write strobe to decoder
//  stream_data   out  8   to decoder
//  stream_valid  out  1   to decoder, one cycle per byte
//  byte_cnt      out  32  bytes forwarded since reset/flush, wraps 0xFFFFFFFF->0
//  overflow      out  1   sticky: cfg_wr seen while full (write dropped)
//  stall         out  1   sticky: busy held BUSY_TIMEOUT consecutive cycles in S_RUN
// BEHAVIOUR
//  Reset: state S_IDLE, FIFO empty, all outputs 0 (cfg_full=0, src_ready=0).
//  FSM states S_IDLE, S_WR, S_GAP, S_RUN:
//   S_IDLE: FIFO non-empty -> S_WR; else play -> S_RUN; else stay.
//   S_WR  : pop FIFO head; next cycle reg_wr_en=1 with its addr/data (registered, latency 1
//           from entry); -> S_GAP, gap counter loaded REG_GAP-1.
//   S_GAP : count down; at 0 -> S_WR if FIFO non-empty, else S_RUN if play, else S_IDLE.
//   S_RUN : FIFO non-empty -> S_WR (priority over stream); else !play -> S_IDLE.
//  reg_addr/reg_dta_in hold last written values between strobes.
//  src_ready = (state==S_RUN) & play & ~busy & fifo_empty. On handshake stream_data<=src_data
//   and stream_valid<=1 next cycle, else stream_valid<=0. Max 1 byte/cycle; byte_cnt += 1.
//  Push to FIFO while full: entry dropped, overflow<=1. Push and pop same cycle: legal at any
//   fill level except full (push dropped); count unchanged when both occur.
//  Push into empty FIFO while in S_RUN: src_ready drops combinationally that cycle.
//  Busy counter: increments while state==S_RUN & busy, clears otherwise; saturates at
//   BUSY_TIMEOUT and sets stall. No state change on stall.
//  flush (any state): next edge -> S_IDLE, FIFO empty, byte_cnt/overflow/stall/busy counter
//   cleared, stream_valid=0, reg_wr_en=0. A strobe already on reg_wr_en this cycle completes.
//   flush wins over a simultaneous cfg_wr (push discarded) and src handshake (src_ready=0
//   in the flush cycle).
//  rst mid-write or mid-gap: identical to reset values; no partial strobe.
// TESTING
//  T1 reset, push 3 writes (a=1,d=0x11;a=2,d=0x22;a=3,d=0x33), play=0 -> three reg_wr_en
//     strobes spaced REG_GAP+1=4 cycles, values in order, then S_IDLE, src_ready=0.
//  T2 play=1, src_valid=1 bytes 0x00..0x0F, busy=0 -> 16 stream_valid pulses, data in order,
//     1-cycle latency, byte_cnt=16.
//  T3 streaming, assert busy 5 cycles -> src_ready=0, no stream_valid during busy; resumes
//     after, no byte lost or duplicated.
//  T4 streaming, push 1 write mid-stream -> src_ready drops same cycle, strobe issued, stream
//     resumes after 3 gap cycles; push 5 with CFG_DEPTH=4 and play=0 -> 5th dropped, overflow=1.
//  T5 preload byte_cnt near wrap via 0xFFFFFFFE start (force) + 3 bytes -> byte_cnt=1;
//     busy held 65535 cycles in S_RUN -> stall=1 exactly on that cycle.
//  T6 flush during S_GAP with 2 queued writes + simultaneous cfg_wr -> next cycle S_IDLE,
//     FIFO empty, no further strobes, overflow/stall/byte_cnt=0.

Source files
------------

// File: rtl/mpeg_stream_ctl.sv
// ---------------------------------------------------------------------------
// mpeg_stream_ctl
//
// Sequences the mpeg2video decoder. Host register writes are queued in a small
// config FIFO and replayed onto reg_addr/reg_dta_in/reg_wr_en, each strobe
// followed by REG_GAP idle cycles. In between, the laserdisc byte stream is
// gated through to stream_data/stream_valid while play is set, the decoder is
// not busy and no config write is waiting.
//
// Ports
//   sys_clk, rst                  clock, synchronous active-high reset
//   cfg_wr/cfg_addr/cfg_data      push one register write into the FIFO
//   cfg_full                      FIFO full (combinational from the fill count)
//   play                          level, permits streaming
//   flush                         pulse, abort: empty FIFO, clear counters/flags
//   src_data/src_valid/src_ready  upstream byte handshake
//   busy                          decoder back-pressure
//   reg_addr/reg_dta_in/reg_wr_en decoder register write port
//   stream_data/stream_valid      decoder byte port, one cycle per byte
//   byte_cnt                      bytes forwarded since reset/flush (wraps)
//   overflow                      sticky, a push arrived while the FIFO was full
//   stall                         sticky, busy held BUSY_TIMEOUT cycles while streaming
// ---------------------------------------------------------------------------
module mpeg_stream_ctl #(
  parameter int CFG_DEPTH    = 4,
  parameter int REG_GAP      = 3,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        cfg_full,
  input  logic        play,
  input  logic        flush,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        busy,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_dta_in,
  output logic        reg_wr_en,
  output logic [7:0]  stream_data,
  output logic        stream_valid,
  output logic [31:0] byte_cnt,
  output logic        overflow,
  output logic        stall
);

  localparam int AW = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;
  localparam int CW = $clog2(CFG_DEPTH + 1);
  localparam int GW = $clog2(REG_GAP + 1);
  localparam int BW = $clog2(BUSY_TIMEOUT + 1);
  localparam int EW = 37;  // {addr[4:0], data[31:0]}

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_GAP  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   gap_reg, gap_next;

  logic [EW-1:0]   fifo_mem [CFG_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;

  logic [4:0]      reg_addr_reg;
  logic [31:0]     reg_dta_reg;
  logic            reg_wr_en_reg;
  logic [7:0]      stream_data_reg;
  logic            stream_valid_reg;
  logic [31:0]     byte_cnt_reg;
  logic            overflow_reg;
  logic            stall_reg;
  logic [BW-1:0]   busy_cnt_reg;

  logic fifo_empty, fifo_full;
  logic push_ok, push_drop, pop, handshake, in_run;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(CFG_DEPTH));
  assign in_run     = (state_reg == S_RUN);

  // flush discards a simultaneous push; a push while full is dropped even if
  // the head is popped in the same cycle.
  assign push_ok   = cfg_wr & ~flush & ~fifo_full;
  assign push_drop = cfg_wr & ~flush & fifo_full;
  // S_WR is only entered with a non-empty FIFO, so no empty check is needed.
  assign pop       = (state_reg == S_WR) & ~flush;

  // A push into an empty FIFO also blocks the stream in the same cycle, so a
  // config write never loses the race against a byte.
  assign src_ready = in_run & play & ~busy & fifo_empty & ~cfg_wr & ~flush;
  assign handshake = src_ready & src_valid;
  assign cfg_full  = fifo_full;

  assign reg_addr     = reg_addr_reg;
  assign reg_dta_in   = reg_dta_reg;
  assign reg_wr_en    = reg_wr_en_reg;
  assign stream_data  = stream_data_reg;
  assign stream_valid = stream_valid_reg;
  assign byte_cnt     = byte_cnt_reg;
  assign overflow     = overflow_reg;
  assign stall        = stall_reg;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty)  state_next = S_WR;
        else if (play)    state_next = S_RUN;
      end
      S_WR: begin
        state_next = S_GAP;
        gap_next   = GW'(REG_GAP - 1);
      end
      S_GAP: begin
        if (gap_reg == '0) begin
          if (!fifo_empty)  state_next = S_WR;
          else if (play)    state_next = S_RUN;
          else              state_next = S_IDLE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      S_RUN: begin
        if (!fifo_empty)  state_next = S_WR;
        else if (!play)   state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
      gap_next   = '0;
    end
  end

  // Config FIFO storage (no reset needed, validity is tracked by count_reg)
  always_ff @(posedge sys_clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {cfg_addr, cfg_data};
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      gap_reg          <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      reg_addr_reg     <= '0;
      reg_dta_reg      <= '0;
      reg_wr_en_reg    <= 1'b0;
      stream_data_reg  <= '0;
      stream_valid_reg <= 1'b0;
      byte_cnt_reg     <= '0;
      overflow_reg     <= 1'b0;
      stall_reg        <= 1'b0;
      busy_cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;

      // pop/handshake are already gated by flush, so both strobes fall to 0
      // on a flush edge while reg_addr/reg_dta_in/stream_data hold.
      reg_wr_en_reg <= pop;
      if (pop) {reg_addr_reg, reg_dta_reg} <= fifo_mem[rd_ptr_reg];

      stream_valid_reg <= handshake;
      if (handshake) stream_data_reg <= src_data;

      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        byte_cnt_reg <= '0;
        overflow_reg <= 1'b0;
        stall_reg    <= 1'b0;
        busy_cnt_reg <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push_ok, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase

        if (handshake) byte_cnt_reg <= byte_cnt_reg + 32'd1;
        if (push_drop) overflow_reg <= 1'b1;

        // Counts consecutive busy cycles while streaming; saturates and
        // raises the sticky stall flag on the cycle it reaches the limit.
        if (in_run && busy) begin
          if (busy_cnt_reg != BW'(BUSY_TIMEOUT)) begin
            busy_cnt_reg <= busy_cnt_reg + 1'b1;
            if (busy_cnt_reg == BW'(BUSY_TIMEOUT - 1)) stall_reg <= 1'b1;
          end
        end else begin
          busy_cnt_reg <= '0;
        end
      end
    end
  end

endmodule
